mem_stage: RTL

//  MEM stage of the 5-stage MIPS pipeline, directly downstream of ID_EX/ALU.

---
 rtl/mips_pkg.sv | 21 ++
 rtl/mem_stage_if.sv | 45 ++++
 rtl/data_mem.sv | 36 +++
 rtl/mem_stage.sv | 185 ++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// Shared MIPS definitions: opcodes, word width, MEM-stage dump FSM encoding
// and an access-alignment helper.
package mips_pkg;

    localparam int WORD_W = 32;

    localparam logic [5:0] OP_LW = 6'b100011;
    localparam logic [5:0] OP_SW = 6'b101011;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DRAIN = 2'd1,
        ST_DUMP  = 2'd2,
        ST_DONE  = 2'd3
    } dump_state_t;

    function automatic logic is_misaligned(input logic [1:0] byte_off, input logic is_mem);
        return is_mem && (byte_off != 2'b00);
    endfunction

endpackage

// File: rtl/mem_stage_if.sv
// EX -> MEM -> WB pipeline bundle plus the end-of-run memory dump stream.
interface mem_stage_if #(
    parameter int ADDR_W = 9
);
    import mips_pkg::*;

    logic                Flush;
    logic                RegWrite_in;
    logic                MemtoReg_in;
    logic                MemWrite_in;
    logic [WORD_W-1:0]   alu_result_in;
    logic [WORD_W-1:0]   store_data_in;
    logic [4:0]          WriteReg_in;
    logic                RegWrite_mem;
    logic [4:0]          WriteReg_mem;
    logic [WORD_W-1:0]   alu_result_mem;
    logic                RegWrite_wb;
    logic                MemtoReg_wb;
    logic [4:0]          WriteReg_wb;
    logic [WORD_W-1:0]   alu_result_wb;
    logic [WORD_W-1:0]   mem_data_wb;
    logic                addr_err;
    logic                dump_start;
    logic                dump_valid;
    logic [ADDR_W-1:0]   dump_addr;
    logic [WORD_W-1:0]   dump_data;
    logic                dump_done;

    modport master (
        output Flush, RegWrite_in, MemtoReg_in, MemWrite_in, alu_result_in,
               store_data_in, WriteReg_in, dump_start,
        input  RegWrite_mem, WriteReg_mem, alu_result_mem, RegWrite_wb, MemtoReg_wb,
               WriteReg_wb, alu_result_wb, mem_data_wb, addr_err, dump_valid,
               dump_addr, dump_data, dump_done
    );

    modport slave (
        input  Flush, RegWrite_in, MemtoReg_in, MemWrite_in, alu_result_in,
               store_data_in, WriteReg_in, dump_start,
        output RegWrite_mem, WriteReg_mem, alu_result_mem, RegWrite_wb, MemtoReg_wb,
               WriteReg_wb, alu_result_wb, mem_data_wb, addr_err, dump_valid,
               dump_addr, dump_data, dump_done
    );

endinterface

// File: rtl/data_mem.sv
// Word-addressed data memory: one synchronous write port, two asynchronous
// read ports (pipeline and dump), whole array cleared by reset.
module data_mem
    import mips_pkg::*;
#(
    parameter int DEPTH  = 512,
    parameter int ADDR_W = 9
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                wr_en,
    input  logic [ADDR_W-1:0]   wr_addr,
    input  logic [WORD_W-1:0]   wr_data,
    input  logic [ADDR_W-1:0]   rd_addr_a,
    output logic [WORD_W-1:0]   rd_data_a,
    input  logic [ADDR_W-1:0]   rd_addr_b,
    output logic [WORD_W-1:0]   rd_data_b
);

    logic [WORD_W-1:0] mem_r [DEPTH];

    // Storage array: async clear, synchronous write
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= {WORD_W{1'b0}};
            end
        end else if (wr_en) begin
            mem_r[wr_addr] <= wr_data;
        end
    end

    assign rd_data_a = mem_r[rd_addr_a];
    assign rd_data_b = mem_r[rd_addr_b];

endmodule

// File: rtl/mem_stage.sv
// MIPS MEM stage: EX_MEM and MEM_WB registers, data memory for lw/sw,
// sticky misalignment flag and an end-of-run memory dump FSM.
module mem_stage
    import mips_pkg::*;
#(
    parameter int DEPTH  = 512,
    parameter int ADDR_W = 9
) (
    input  logic        CLOCK,
    input  logic        RESET_N,
    mem_stage_if.slave  bus
);

    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(DEPTH - 1);

    logic                regwrite_mem_r;
    logic                memtoreg_mem_r;
    logic                memwrite_mem_r;
    logic [WORD_W-1:0]   alu_mem_r;
    logic [WORD_W-1:0]   store_data_mem_r;
    logic [4:0]          writereg_mem_r;

    logic                regwrite_wb_r;
    logic                memtoreg_wb_r;
    logic [4:0]          writereg_wb_r;
    logic [WORD_W-1:0]   alu_wb_r;
    logic [WORD_W-1:0]   mem_data_wb_r;
    logic                addr_err_r;

    dump_state_t         state_r;
    dump_state_t         state_nxt_s;
    logic [ADDR_W-1:0]   dump_addr_r;
    logic [ADDR_W-1:0]   dump_addr_nxt_s;
    logic                dump_valid_r;
    logic                dump_valid_nxt_s;
    logic                dump_done_r;
    logic                dump_done_nxt_s;

    logic [ADDR_W-1:0]   word_idx_s;
    logic                misaligned_s;
    logic                store_open_s;
    logic                wr_en_s;
    logic [WORD_W-1:0]   rd_data_s;
    logic [WORD_W-1:0]   dump_rd_s;
    logic [WORD_W-1:0]   load_data_s;

    data_mem #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_data_mem (
        .clk       (CLOCK),
        .rst_n     (RESET_N),
        .wr_en     (wr_en_s),
        .wr_addr   (word_idx_s),
        .wr_data   (store_data_mem_r),
        .rd_addr_a (word_idx_s),
        .rd_data_a (rd_data_s),
        .rd_addr_b (dump_addr_r),
        .rd_data_b (dump_rd_s)
    );

    // EX_MEM register; a flush squashes only the control bits
    always_ff @(posedge CLOCK or negedge RESET_N) begin
        if (!RESET_N) begin
            regwrite_mem_r   <= 1'b0;
            memtoreg_mem_r   <= 1'b0;
            memwrite_mem_r   <= 1'b0;
            alu_mem_r        <= {WORD_W{1'b0}};
            store_data_mem_r <= {WORD_W{1'b0}};
            writereg_mem_r   <= 5'd0;
        end else begin
            if (bus.Flush) begin
                regwrite_mem_r <= 1'b0;
                memtoreg_mem_r <= 1'b0;
                memwrite_mem_r <= 1'b0;
            end else begin
                regwrite_mem_r <= bus.RegWrite_in;
                memtoreg_mem_r <= bus.MemtoReg_in;
                memwrite_mem_r <= bus.MemWrite_in;
            end
            alu_mem_r        <= bus.alu_result_in;
            store_data_mem_r <= bus.store_data_in;
            writereg_mem_r   <= bus.WriteReg_in;
        end
    end

    // Memory access decode for the instruction in EX_MEM; stores are only open before the dump streams
    always_comb begin
        word_idx_s   = alu_mem_r[ADDR_W+1:2];
        misaligned_s = is_misaligned(alu_mem_r[1:0], memwrite_mem_r | memtoreg_mem_r);
        store_open_s = (state_r == ST_IDLE) || (state_r == ST_DRAIN);
        wr_en_s      = memwrite_mem_r && !misaligned_s && store_open_s;
        if (memtoreg_mem_r && !misaligned_s) begin
            load_data_s = rd_data_s;
        end else begin
            load_data_s = {WORD_W{1'b0}};
        end
    end

    // MEM_WB register and sticky misalignment flag
    always_ff @(posedge CLOCK or negedge RESET_N) begin
        if (!RESET_N) begin
            regwrite_wb_r <= 1'b0;
            memtoreg_wb_r <= 1'b0;
            writereg_wb_r <= 5'd0;
            alu_wb_r      <= {WORD_W{1'b0}};
            mem_data_wb_r <= {WORD_W{1'b0}};
            addr_err_r    <= 1'b0;
        end else begin
            regwrite_wb_r <= regwrite_mem_r;
            memtoreg_wb_r <= memtoreg_mem_r;
            writereg_wb_r <= writereg_mem_r;
            alu_wb_r      <= alu_mem_r;
            mem_data_wb_r <= load_data_s;
            addr_err_r    <= addr_err_r | misaligned_s;
        end
    end

    // Dump FSM next state: DRAIN gives an in-flight store one cycle to land
    always_comb begin
        state_nxt_s      = state_r;
        dump_addr_nxt_s  = dump_addr_r;
        dump_valid_nxt_s = 1'b0;
        dump_done_nxt_s  = dump_done_r;
        case (state_r)
            ST_IDLE: begin
                if (bus.dump_start) begin
                    state_nxt_s = ST_DRAIN;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_DRAIN: begin
                state_nxt_s      = ST_DUMP;
                dump_addr_nxt_s  = {ADDR_W{1'b0}};
                dump_valid_nxt_s = 1'b1;
            end
            ST_DUMP: begin
                if (dump_addr_r == LAST_IDX) begin
                    state_nxt_s     = ST_DONE;
                    dump_done_nxt_s = 1'b1;
                end else begin
                    dump_addr_nxt_s  = dump_addr_r + ADDR_W'(1'b1);
                    dump_valid_nxt_s = 1'b1;
                end
            end
            ST_DONE: begin
                dump_done_nxt_s = 1'b1;
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // Dump FSM registers
    always_ff @(posedge CLOCK or negedge RESET_N) begin
        if (!RESET_N) begin
            state_r      <= ST_IDLE;
            dump_addr_r  <= {ADDR_W{1'b0}};
            dump_valid_r <= 1'b0;
            dump_done_r  <= 1'b0;
        end else begin
            state_r      <= state_nxt_s;
            dump_addr_r  <= dump_addr_nxt_s;
            dump_valid_r <= dump_valid_nxt_s;
            dump_done_r  <= dump_done_nxt_s;
        end
    end

    assign bus.RegWrite_mem   = regwrite_mem_r;
    assign bus.WriteReg_mem   = writereg_mem_r;
    assign bus.alu_result_mem = alu_mem_r;
    assign bus.RegWrite_wb    = regwrite_wb_r;
    assign bus.MemtoReg_wb    = memtoreg_wb_r;
    assign bus.WriteReg_wb    = writereg_wb_r;
    assign bus.alu_result_wb  = alu_wb_r;
    assign bus.mem_data_wb    = mem_data_wb_r;
    assign bus.addr_err       = addr_err_r;
    assign bus.dump_valid     = dump_valid_r;
    assign bus.dump_addr      = dump_addr_r;
    assign bus.dump_data      = dump_valid_r ? dump_rd_s : {WORD_W{1'b0}};
    assign bus.dump_done      = dump_done_r;

endmodule
